// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// alu_seq_ctrl : ALU op sequencer, 1-cycle logic/arith ops, iterative mul/div
//                (optional MUL early termination: ALU_SEQ_EARLY_TERM_EN)
// Revision     : 1.0
// ============================================================================
module alu_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [2:0]       alu_ctrl_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic [3:0]       flags_o,
    output logic             wr_en_o,
    output logic             busy_o
);

    localparam int SW = $clog2(WIDTH);
    localparam int CW = SW + 1;
`ifdef ALU_SEQ_EARLY_TERM_EN
    localparam bit EARLY_TERM = 1'b1;
`else
    localparam bit EARLY_TERM = 1'b0;
`endif

    localparam logic [2:0] OP_SUB = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_ORR = 3'b110;
    localparam logic [2:0] OP_CMP = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] opa_q, opa_d;   // multiplicand / dividend-then-quotient
    logic [WIDTH-1:0] opb_q, opb_d;   // multiplier / divisor
    logic [WIDTH-1:0] acc_q, acc_d;   // product accumulator / partial remainder
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic             wr_en_q, wr_en_d;

    logic [WIDTH:0]   w_sum, w_diff, w_trial;
    logic [WIDTH-1:0] w_mul_acc, w_mul_b_next, w_quot_next;
    logic             w_qbit;
    logic             ld_en, ld_c, ld_v;
    logic [WIDTH-1:0] ld_res;

    assign w_sum  = {1'b0, a_i} + {1'b0, b_i};
    assign w_diff = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};

    assign w_mul_acc    = acc_q + (opb_q[0] ? opa_q : '0);
    assign w_mul_b_next = opb_q >> 1;

    // Restoring step: bring in the next dividend bit, subtract if it fits.
    assign w_trial     = {acc_q, opa_q[WIDTH-1]} - {1'b0, opb_q};
    assign w_qbit      = ~w_trial[WIDTH];
    assign w_quot_next = {opa_q[WIDTH-2:0], w_qbit};

    assign req_ready_o = (state_q == IDLE) && !flush_i;
    assign rsp_valid_o = (state_q == DONE) && !flush_i;
    assign busy_o      = (state_q != IDLE);
    assign result_o    = result_q;
    assign flags_o     = flags_q;
    assign wr_en_o     = wr_en_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        result_d = result_q;
        flags_d  = flags_q;
        wr_en_d  = wr_en_q;
        ld_en    = 1'b0;
        ld_res   = '0;
        ld_c     = 1'b0;
        ld_v     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid_i && req_ready_o) begin
                    wr_en_d = (alu_ctrl_i != OP_CMP);
                    case (alu_ctrl_i)
                        OP_SUB, OP_CMP: begin
                            ld_en  = 1'b1;
                            ld_res = w_diff[WIDTH-1:0];
                            ld_c   = w_diff[WIDTH];
                            ld_v   = (a_i[WIDTH-1] != b_i[WIDTH-1]) &&
                                     (w_diff[WIDTH-1] != a_i[WIDTH-1]);
                        end
                        OP_ADD: begin
                            ld_en  = 1'b1;
                            ld_res = w_sum[WIDTH-1:0];
                            ld_c   = w_sum[WIDTH];
                            ld_v   = (a_i[WIDTH-1] == b_i[WIDTH-1]) &&
                                     (w_sum[WIDTH-1] != a_i[WIDTH-1]);
                        end
                        OP_AND: begin
                            ld_en  = 1'b1;
                            ld_res = a_i & b_i;
                        end
                        OP_ORR: begin
                            ld_en  = 1'b1;
                            ld_res = a_i | b_i;
                        end
                        OP_SLL: begin
                            ld_en  = 1'b1;
                            ld_res = a_i << b_i[SW-1:0];
                        end
                        OP_MUL: begin
                            if (EARLY_TERM && (b_i == '0)) begin
                                ld_en = 1'b1;
                            end else begin
                                opa_d   = a_i;
                                opb_d   = b_i;
                                acc_d   = '0;
                                cnt_d   = CW'(WIDTH);
                                state_d = MUL;
                            end
                        end
                        OP_DIV: begin
                            if (b_i == '0) begin
                                ld_en  = 1'b1;
                                ld_res = '1;
                                ld_v   = 1'b1;
                            end else begin
                                opa_d   = a_i;
                                opb_d   = b_i;
                                acc_d   = '0;
                                cnt_d   = CW'(WIDTH);
                                state_d = DIV;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            MUL: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    acc_d = w_mul_acc;
                    opa_d = opa_q << 1;
                    opb_d = w_mul_b_next;
                    cnt_d = cnt_q - CW'(1);
                    if ((cnt_q == CW'(1)) || (EARLY_TERM && (w_mul_b_next == '0))) begin
                        ld_en  = 1'b1;
                        ld_res = w_mul_acc;
                    end
                end
            end
            DIV: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    acc_d = w_qbit ? w_trial[WIDTH-1:0] : {acc_q[WIDTH-2:0], opa_q[WIDTH-1]};
                    opa_d = w_quot_next;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        ld_en  = 1'b1;
                        ld_res = w_quot_next;
                    end
                end
            end
            DONE: begin
                if (flush_i || rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (ld_en) begin
            result_d = ld_res;
            flags_d  = {ld_res[WIDTH-1], (ld_res == '0), ld_c, ld_v};
            state_d  = DONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
            wr_en_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            wr_en_q  <= wr_en_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// tb_alu_seq_ctrl : self-checking bench for alu_seq_ctrl with a reference model
// Revision        : 1.0
// ============================================================================
module tb_alu_seq_ctrl;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [2:0]   alu_ctrl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         flush;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] result;
    logic [3:0]   flags;
    logic         wr_en;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    alu_seq_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .alu_ctrl_i (alu_ctrl),
        .a_i        (a),
        .b_i        (b),
        .flush_i    (flush),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .result_o   (result),
        .flags_o    (flags),
        .wr_en_o    (wr_en),
        .busy_o     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: results from plain integer arithmetic.
    function automatic void model(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] r, output logic [3:0] f,
                                  output logic wr, output int lat);
        longint sd;
        logic [63:0] p;
        logic c, v;
        int h;
        c = 1'b0; v = 1'b0; lat = 1; wr = (op != 3'd7); r = '0;
        case (op)
            3'd0, 3'd7: begin
                r  = x - y;
                c  = (x >= y);
                sd = longint'($signed(x)) - longint'($signed(y));
                v  = (sd != longint'($signed(r)));
            end
            3'd1: begin
                r  = x + y;
                c  = ((longint'({32'b0, x}) + longint'({32'b0, y})) > 64'h0000_0000_FFFF_FFFF);
                sd = longint'($signed(x)) + longint'($signed(y));
                v  = (sd != longint'($signed(r)));
            end
            3'd2: begin
                p = {32'b0, x} * {32'b0, y};
                r = p[31:0];
`ifdef ALU_SEQ_EARLY_TERM_EN
                h = -1;
                for (int i = 0; i < W; i++) if (y[i]) h = i;
                lat = (h < 0) ? 1 : h + 2;
`else
                lat = W + 1;
`endif
            end
            3'd3: begin
                if (y == 0) begin
                    r = '1; v = 1'b1;
                end else begin
                    r = x / y; lat = W + 1;
                end
            end
            3'd4: r = x & y;
            3'd5: r = x << (y % W);
            3'd6: r = x | y;
            default: ;
        endcase
        f = {r[W-1], (r == 0), c, v};
    endfunction

    // Issue one op, wait (bounded) for the response, capture it, then handshake.
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                          output logic [W-1:0] r, output logic [3:0] f,
                          output logic wr, output int lat);
        int guard;
        @(negedge clk);
        req_valid = 1'b1; alu_ctrl = op; a = x; b = y; rsp_ready = 1'b0;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk); guard++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            @(negedge clk); lat++;
        end
        if (!rsp_valid) begin
            checks++; failures++;
            $display("FAIL rsp_timeout op=%0d got rsp_valid=0 want 1", op);
        end
        r = result; f = flags; wr = wr_en;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (result !== '0) begin failures++; $display("FAIL reset_result got %h want 0", result); end
        checks++; if (flags !== 4'b0) begin failures++; $display("FAIL reset_flags got %b want 0000", flags); end
        checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
    endtask

    task automatic test_directed();
        logic [W-1:0] r, er; logic [3:0] f, ef; logic wr, ewr; int lat, elat;
        run_op(3'd1, 32'h7FFF_FFFF, 32'h1, r, f, wr, lat);
        checks++; if (r !== 32'h8000_0000) begin failures++; $display("FAIL add_ovf_result got %h want 80000000", r); end
        checks++; if (f !== 4'b1001) begin failures++; $display("FAIL add_ovf_flags got %b want 1001", f); end
        checks++; if (wr !== 1'b1) begin failures++; $display("FAIL add_ovf_wr_en got %b want 1", wr); end
        checks++; if (lat !== 1) begin failures++; $display("FAIL add_latency got %0d want 1", lat); end

        run_op(3'd7, 32'd5, 32'd5, r, f, wr, lat);
        checks++; if (r !== 32'h0) begin failures++; $display("FAIL cmp_result got %h want 0", r); end
        checks++; if (f !== 4'b0110) begin failures++; $display("FAIL cmp_flags got %b want 0110", f); end
        checks++; if (wr !== 1'b0) begin failures++; $display("FAIL cmp_wr_en got %b want 0", wr); end

        run_op(3'd2, 32'h0000_FFFF, 32'h0001_0001, r, f, wr, lat);
        model(3'd2, 32'h0000_FFFF, 32'h0001_0001, er, ef, ewr, elat);
        checks++; if (r !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mul_result got %h want ffffffff", r); end
        checks++; if (lat !== elat) begin failures++; $display("FAIL mul_latency got %0d want %0d", lat, elat); end

`ifdef ALU_SEQ_EARLY_TERM_EN
        run_op(3'd2, 32'd3, 32'd2, r, f, wr, lat);
        checks++; if (r !== 32'd6) begin failures++; $display("FAIL mul_early_result got %0d want 6", r); end
        checks++; if (lat !== 3) begin failures++; $display("FAIL mul_early_latency got %0d want 3", lat); end
`endif

        run_op(3'd3, 32'd100, 32'd7, r, f, wr, lat);
        checks++; if (r !== 32'd14) begin failures++; $display("FAIL div_result got %0d want 14", r); end
        checks++; if (lat !== 33) begin failures++; $display("FAIL div_latency got %0d want 33", lat); end

        run_op(3'd3, 32'd5, 32'd0, r, f, wr, lat);
        checks++; if (r !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div0_result got %h want ffffffff", r); end
        checks++; if (f !== 4'b1001) begin failures++; $display("FAIL div0_flags got %b want 1001", f); end
        checks++; if (lat !== 1) begin failures++; $display("FAIL div0_latency got %0d want 1", lat); end
    endtask

    task automatic test_random();
        logic [W-1:0] x, y, r, er; logic [3:0] f, ef; logic wr, ewr; int lat, elat;
        logic [2:0] op;
        for (int n = 0; n < 60; n++) begin
            op = 3'($urandom_range(0, 7));
            x  = $urandom;
            case ($urandom_range(0, 7))
                0:       y = '0;
                1, 2:    y = 32'($urandom_range(1, 15));
                3:       y = x;
                default: y = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) x = 32'h8000_0000;
            model(op, x, y, er, ef, ewr, elat);
            run_op(op, x, y, r, f, wr, lat);
            checks++; if (r !== er) begin failures++; $display("FAIL rand_result op=%0d a=%h b=%h got %h want %h", op, x, y, r, er); end
            checks++; if (f !== ef) begin failures++; $display("FAIL rand_flags op=%0d a=%h b=%h got %b want %b", op, x, y, f, ef); end
            checks++; if (wr !== ewr) begin failures++; $display("FAIL rand_wr_en op=%0d got %b want %b", op, wr, ewr); end
            checks++; if (lat !== elat) begin failures++; $display("FAIL rand_latency op=%0d b=%h got %0d want %0d", op, y, lat, elat); end
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        req_valid = 1'b1; alu_ctrl = 3'd1; a = 32'd3; b = 32'd4; rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a = 32'd100; b = 32'd200;
        for (int i = 0; i < 10; i++) begin
            checks++; if (result !== 32'd7) begin failures++; $display("FAIL bp_result cyc=%0d got %0d want 7", i, result); end
            checks++; if (flags !== 4'b0000) begin failures++; $display("FAIL bp_flags cyc=%0d got %b want 0000", i, flags); end
            checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL bp_req_ready cyc=%0d got %b want 0", i, req_ready); end
            checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_rsp_valid cyc=%0d got %b want 1", i, rsp_valid); end
            @(negedge clk);
        end
        rsp_ready = 1'b1; a = 32'd10; b = 32'd20;
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL bp_handshake_req_ready got %b want 0", req_ready); end
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_after_hs_rsp_valid got %b want 0", rsp_valid); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL bp_after_hs_req_ready got %b want 1", req_ready); end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || result !== 32'd30) begin
            failures++; $display("FAIL bp_next_op got valid=%b result=%0d want valid=1 result=30", rsp_valid, result);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_flush();
        logic [W-1:0] r; logic [3:0] f; logic wr; int lat; bit seen;
        @(negedge clk);
        req_valid = 1'b1; alu_ctrl = 3'd3; a = 32'd1000; b = 32'd3; rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_div_busy got %b want 0", busy); end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid) seen = 1'b1;
            @(negedge clk);
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL flush_div_no_rsp got rsp seen=%b want 0", seen); end
        rsp_ready = 1'b0;

        run_op(3'd5, 32'd1, 32'd35, r, f, wr, lat);
        checks++; if (r !== 32'd8) begin failures++; $display("FAIL sll_result got %0d want 8", r); end
        checks++; if (lat !== 1) begin failures++; $display("FAIL sll_latency got %0d want 1", lat); end

        @(negedge clk);
        flush = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL flush_idle_req_ready got %b want 0", req_ready); end
        flush = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL idle_req_ready got %b want 1", req_ready); end

        @(negedge clk);
        req_valid = 1'b1; alu_ctrl = 3'd4; a = 32'hF0F0; b = 32'hFF00;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL flush_done_pre got %b want 1", rsp_valid); end
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            failures++; $display("FAIL flush_done got busy=%b rsp_valid=%b want 0 0", busy, rsp_valid);
        end
    endtask

    task automatic test_reset_mid_mul();
        bit seen;
        @(negedge clk);
        req_valid = 1'b1; alu_ctrl = 3'd2; a = 32'd7; b = 32'd9; rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got %b want 0", busy); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_rsp_valid got %b want 0", rsp_valid); end
        checks++; if (result !== '0) begin failures++; $display("FAIL rst_mid_result got %h want 0", result); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid) seen = 1'b1;
            @(negedge clk);
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rst_mid_no_rsp got rsp seen=%b want 0", seen); end
        rsp_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; alu_ctrl = 3'd0; a = '0; b = '0;
        flush = 1'b0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_flush();
        test_reset_mid_mul();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
